imem_loader: RTL and testbench

- Host-side writer for the core's instruction-memory load port; drives what the core samples: `reset_IF_memory`, `rw`, `instruction_in`, `PC_write`, plus core `reset`.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Writes each instruction at consecutive PCs from 0 and holds the core in reset until the load completes cleanly.

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_word_assembler.sv | 32 +++
 rtl/imem_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encoding, word geometry and byte-index width.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_COLLECT,
        ST_WRITE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BIDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word assembler with byte index and running byte sum.
// The sum is only consumed when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [7:0]        byte_in,
    output logic [BIDX_W-1:0] idx,
    output logic [31:0]       word,
    output logic [7:0]        sum
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx  <= '0;
            word <= '0;
            sum  <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
            sum  <= '0;
        end else if (load) begin
            word[8*idx +: 8] <= byte_in;
            idx              <= idx + 1'b1;
            sum              <= sum + byte_in;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory and holds the core in reset
// until a clean load; optional trailing checksum via IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int PC_SIZE = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    input  logic               byte_last,
    output logic               byte_ready,
    output logic               core_reset,
    output logic               reset_if_mem,
    output logic               rw,
    output logic [31:0]        instruction_out,
    output logic [PC_SIZE-1:0] pc_write_out,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [PC_SIZE:0]   word_count
);

    state_t state_q, state_d;

    logic [PC_SIZE-1:0] addr_q;
    logic [PC_SIZE-1:0] pc_q;
    logic [31:0]        instr_q;
    logic               last_q;
    logic               set_done, set_err, img_fire, fire;
    logic [BIDX_W-1:0]  idx;
    logic [31:0]        asm_word;
    logic [7:0]         sum;

    assign fire = byte_valid && byte_ready;

    imem_word_assembler u_asm (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == ST_CLEAR),
        .load    (img_fire),
        .byte_in (byte_in),
        .idx     (idx),
        .word    (asm_word),
        .sum     (sum)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] chk_total;
    assign chk_total = sum + byte_in;
`else
    logic unused_sum;
    assign unused_sum = ^sum;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        byte_ready   = 1'b0;
        rw           = 1'b0;
        reset_if_mem = 1'b0;
        set_done     = 1'b0;
        set_err      = 1'b0;
        img_fire     = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_CLEAR;
            ST_CLEAR: begin
                reset_if_mem = 1'b1;
                state_d      = ST_COLLECT;
            end
            ST_COLLECT: begin
                byte_ready = 1'b1;
                if (fire) begin
                    // Capacity exhausted: the byte is taken but never stored
                    if (word_count[PC_SIZE]) begin
                        set_err = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        img_fire = 1'b1;
                        if (idx == LAST_IDX) begin
                            state_d = ST_WRITE;
                        end else if (byte_last) begin
                            set_err = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_WRITE: begin
                rw = 1'b1;
                if (last_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    set_done = 1'b1;
                    state_d  = ST_DONE;
`endif
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                byte_ready = 1'b1;
                if (fire) begin
                    state_d  = ST_DONE;
                    set_done = (chk_total == 8'h00);
                    set_err  = (chk_total != 8'h00);
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: if (start) state_d = ST_CLEAR;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q     <= '0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            last_q     <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
        end else begin
            if (state_q == ST_CLEAR) begin
                addr_q     <= '0;
                word_count <= '0;
                done       <= 1'b0;
                error      <= 1'b0;
                last_q     <= 1'b0;
            end
            if (img_fire && idx == LAST_IDX) last_q <= byte_last;
            if (state_q == ST_WRITE) begin
                instr_q    <= asm_word;
                pc_q       <= addr_q;
                word_count <= word_count + 1'b1;
                if (addr_q != {PC_SIZE{1'b1}}) addr_q <= addr_q + 1'b1;
            end
            if (set_done) done <= 1'b1;
            if (set_err) error <= 1'b1;
        end
    end

    assign busy = (state_q == ST_CLEAR) || (state_q == ST_COLLECT) ||
                  (state_q == ST_WRITE) || (state_q == ST_CHECK);
    assign core_reset = !((state_q == ST_DONE) && !error);
    assign instruction_out = (state_q == ST_WRITE) ? asm_word : instr_q;
    assign pc_write_out = (state_q == ST_WRITE) ? addr_q : pc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word image space.
module tb_imem_loader;

    localparam int PCS = 2;

    logic           clock;
    logic           reset;
    logic           start;
    logic [7:0]     byte_in;
    logic           byte_valid;
    logic           byte_last;
    logic           byte_ready;
    logic           core_reset;
    logic           reset_if_mem;
    logic           rw;
    logic [31:0]    instruction_out;
    logic [PCS-1:0] pc_write_out;
    logic           busy;
    logic           done;
    logic           error;
    logic [PCS:0]   word_count;

    int tests = 0;
    int fails = 0;
    int br_viol = 0;
    int clr_cnt = 0;
    logic [31:0] wr_data[$];
    logic [31:0] wr_pc[$];
    logic [7:0]  img[$];

    imem_loader #(.PC_SIZE(PCS)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .byte_in         (byte_in),
        .byte_valid      (byte_valid),
        .byte_last       (byte_last),
        .byte_ready      (byte_ready),
        .core_reset      (core_reset),
        .reset_if_mem    (reset_if_mem),
        .rw              (rw),
        .instruction_out (instruction_out),
        .pc_write_out    (pc_write_out),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .word_count      (word_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            if (rw) begin
                wr_data.push_back(instruction_out);
                wr_pc.push_back(32'(pc_write_out));
            end
            if (byte_ready && (rw || reset_if_mem)) br_viol++;
            if (reset_if_mem) clr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_data.delete();
        wr_pc.delete();
        clr_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last,
                             input bit gaps);
        bit ok;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                @(posedge clock); #1;
            end
        end
        byte_in    = b;
        byte_last  = last;
        byte_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clock);
            ok = byte_ready;
            @(posedge clock); #1;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        if (!ok) check("byte_timeout", 0, 1);
    endtask

    task automatic send_img(input int last_at, input bit gaps);
        for (int i = 0; i < img.size(); i++)
            send_byte(img[i], i == last_at, gaps);
    endtask

    task automatic wait_end();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clock);
            hit = done || error;
        end
        if (!hit) check("end_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        byte_in = '0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        #12;
        check("rst_core_reset", core_reset, 1);
        check("rst_outs", {reset_if_mem, rw, busy, done, error, byte_ready},
              0);
        check("rst_instr", instruction_out, 0);
        check("rst_pc_cnt", {pc_write_out, word_count}, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // nominal two-word load
        clear_log();
        pulse_start();
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_img(7, 0);
        wait_end();
        check("nom_core_reset", core_reset, 0);
        check("nom_flags", {done, error}, 2'b10);
        check("nom_count", word_count, 2);
        check("nom_writes", wr_data.size(), 2);
        if (wr_data.size() == 2) begin
            check("nom_w0", {wr_pc[0], wr_data[0]}, {32'd0, 32'h00000013});
            check("nom_w1", {wr_pc[1], wr_data[1]}, {32'd1, 32'h00100093});
        end
        check("nom_clr", clr_cnt, 1);

        // partial trailing word
        clear_log();
        pulse_start();
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_img(5, 0);
        wait_end();
        repeat (2) @(negedge clock);
        check("part_flags", {done, error}, 2'b01);
        check("part_core_reset", core_reset, 1);
        check("part_writes", wr_data.size(), 1);
        if (wr_data.size() == 1)
            check("part_w0", {wr_pc[0], wr_data[0]}, {32'd0, 32'h04030201});
        check("part_count", word_count, 1);

        // overflow on a 4-word space
        clear_log();
        pulse_start();
        img.delete();
        for (int i = 0; i < 17; i++) img.push_back(8'(8'h40 + i));
        send_img(-1, 0);
        wait_end();
        check("ovf_flags", {done, error}, 2'b01);
        check("ovf_writes", wr_data.size(), 4);
        if (wr_data.size() == 4) begin
            check("ovf_pcs", {wr_pc[0][1:0], wr_pc[1][1:0], wr_pc[2][1:0],
                              wr_pc[3][1:0]}, 8'b00_01_10_11);
            check("ovf_w3", wr_data[3], 32'h4f4e4d4c);
        end
        check("ovf_pc_hold", pc_write_out, 3);
        check("ovf_count", word_count, 4);
        check("ovf_core_reset", core_reset, 1);

        // gaps plus an ignored start while busy
        clear_log();
        pulse_start();
        img = '{8'hde, 8'had, 8'hbe, 8'hef, 8'h01, 8'h23, 8'h45, 8'h67};
        for (int i = 0; i < 3; i++) send_byte(img[i], 0, 1);
        pulse_start();
        for (int i = 3; i < 8; i++) send_byte(img[i], i == 7, 1);
        wait_end();
        check("gap_flags", {done, error}, 2'b10);
        check("gap_clr", clr_cnt, 1);
        check("gap_writes", wr_data.size(), 2);
        if (wr_data.size() == 2) begin
            check("gap_w0", {wr_pc[0], wr_data[0]}, {32'd0, 32'hefbeadde});
            check("gap_w1", {wr_pc[1], wr_data[1]}, {32'd1, 32'h67452301});
        end
        check("ready_while_busy_edge", br_viol, 0);

        // asynchronous reset mid-load, then a fresh image
        clear_log();
        pulse_start();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_img(-1, 0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_outs", {core_reset, rw, busy, done, error, byte_ready,
                               reset_if_mem}, 7'b1000000);
        check("mid_rst_cnt", {word_count, pc_write_out}, 0);
        check("mid_rst_instr", instruction_out, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        clear_log();
        pulse_start();
        img = '{8'h33, 8'h22, 8'h11, 8'h00};
        send_img(3, 0);
        wait_end();
        check("rst2_flags", {done, error, core_reset}, 3'b100);
        check("rst2_writes", wr_data.size(), 1);
        if (wr_data.size() == 1)
            check("rst2_w0", {wr_pc[0], wr_data[0]}, {32'd0, 32'h00112233});
        check("rst2_clr", clr_cnt, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        clear_log();
        pulse_start();
        img = '{8'h13, 8'h00, 8'h00, 8'h00};
        send_img(3, 0);
        send_byte(8'hed, 0, 0);
        wait_end();
        check("chk_good", {done, error, core_reset}, 3'b100);
        pulse_start();
        send_img(3, 0);
        send_byte(8'hee, 0, 0);
        wait_end();
        check("chk_bad", {done, error, core_reset}, 3'b011);
`endif

        check("ready_violations", br_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
